// File: rtl/snn_pkg.sv
// Shared SNN NoC definitions: packet layout, opcodes, node ids and the omem FSM state type.
package snn_pkg;

    localparam int PKT_W    = 33;
    localparam int ADDR_MSB = 32;
    localparam int ADDR_LSB = 29;
    localparam int OP_MSB   = 28;
    localparam int OP_LSB   = 25;
    localparam int DATA_MSB = 24;
    localparam int DATA_LSB = 0;
    localparam int PE_W     = 3;
    localparam int MAX_SPE  = 1 << PE_W;

    localparam logic [3:0] OP_PARTIAL_SUM         = 4'd0;
    localparam logic [3:0] OP_PREV_POTENTIAL      = 4'd2;
    localparam logic [3:0] OP_FIRST_TIMESTEP_DONE = 4'd15;

    localparam logic [3:0] OMEM_ID   = 4'd12;
    localparam int         SUM_WIDTH = 13;

    typedef struct packed {
        logic [ADDR_MSB-ADDR_LSB:0] addr;
        logic [OP_MSB-OP_LSB:0]     opcode;
        logic [DATA_MSB-DATA_LSB:0] data;
    } packet_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_RESP,
        ST_TS_BCAST,
        ST_DONE
    } omem_state_e;

endpackage

// File: rtl/omem_array.sv
// Neuron state storage: one write port, one asynchronous read port, contents cleared on reset.
module omem_array #(
    parameter int DEPTH = 441,
    parameter int WIDTH = 14,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/omem.sv
// Output/potential memory node: stores per-neuron potentials from sum PEs, serves reads, tracks timesteps.
// Optional OMEM_SPIKE_COUNT_EN adds spike_count / last_spike_count outputs.
module omem
    import snn_pkg::*;
#(
    parameter int NUM_SPE         = 3,
    parameter int NEURONS_PER_SPE = 147,
    parameter int NUM_TIMESTEPS   = 10,
    parameter int OMEM_ADDR       = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [32:0] in_packet,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:0] out_packet,
    output logic [3:0]  timestep,
    output logic        done,
    output logic        err
`ifdef OMEM_SPIKE_COUNT_EN
    ,
    output logic [8:0]  spike_count,
    output logic [8:0]  last_spike_count
`endif
);

    localparam int DEPTH = NUM_SPE * NEURONS_PER_SPE;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = $clog2(NEURONS_PER_SPE);
    localparam logic [MAX_SPE-1:0] ALL_DONE = MAX_SPE'((1 << NUM_SPE) - 1);

    omem_state_e state, state_nxt;

    packet_t in_pkt;
    packet_t out_pkt;

    logic                 started;
    logic [PW-1:0]        ptr [MAX_SPE];
    logic [MAX_SPE-1:0]   spe_done;
    logic [MAX_SPE-1:0]   done_set;
    logic [PE_W-1:0]      bcast_idx;
    logic [PE_W-1:0]      resp_pe;
    logic [SUM_WIDTH-1:0] resp_pot;

    logic [PE_W-1:0]      pe;
    logic                 is_rd;
    logic                 drop;
    logic                 stall;
    logic                 accept;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 ptr_last;
    logic                 ts_close;
    logic                 bcast_last;
    logic [PW-1:0]        ptr_prev;
    logic [3:0]           ts_inc;
    logic [AW-1:0]        waddr;
    logic [AW-1:0]        raddr;
    logic [SUM_WIDTH:0]   rdata;
    logic                 unused_bits;

    assign in_pkt      = in_packet;
    assign unused_bits = ^{rdata[0], in_pkt.data[DATA_MSB:SUM_WIDTH+1]};

    always_comb begin
        pe       = in_pkt.opcode[3:1];
        is_rd    = in_pkt.opcode[0];
        drop     = (in_pkt.addr != 4'(OMEM_ADDR)) || (int'(pe) >= NUM_SPE);
        stall    = !drop && spe_done[pe];
        in_ready = started && (state == ST_IDLE) && !stall;
        accept   = in_valid && in_ready;
        wr_acc   = accept && !drop && !is_rd;
        rd_acc   = accept && !drop && is_rd;
        ptr_last = (ptr[pe] == PW'(NEURONS_PER_SPE - 1));
        // Reads return the PE's most recently written neuron, so a write is visible to the next read.
        ptr_prev = (ptr[pe] == '0) ? PW'(NEURONS_PER_SPE - 1) : ptr[pe] - 1'b1;
        waddr    = AW'(pe) * AW'(NEURONS_PER_SPE) + AW'(ptr[pe]);
        raddr    = AW'(pe) * AW'(NEURONS_PER_SPE) + AW'(ptr_prev);
        done_set = spe_done;
        if (wr_acc && ptr_last) begin
            done_set[pe] = 1'b1;
        end
        ts_close   = wr_acc && ptr_last && ((done_set & ALL_DONE) == ALL_DONE);
        ts_inc     = timestep + 4'd1;
        bcast_last = (bcast_idx == PE_W'(NUM_SPE - 1));
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_pkt   = '0;
        case (state)
            ST_IDLE: begin
                if (rd_acc) begin
                    state_nxt = ST_RD_RESP;
                end else if (ts_close) begin
                    if (timestep == '0) begin
                        state_nxt = ST_TS_BCAST;
                    end else if (ts_inc == 4'(NUM_TIMESTEPS)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_RD_RESP: begin
                out_valid      = 1'b1;
                out_pkt.addr   = 4'(resp_pe);
                out_pkt.opcode = OP_PREV_POTENTIAL;
                out_pkt.data   = 25'(resp_pot);
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TS_BCAST: begin
                out_valid      = 1'b1;
                out_pkt.addr   = 4'(bcast_idx);
                out_pkt.opcode = OP_FIRST_TIMESTEP_DONE;
                if (out_ready && bcast_last) begin
                    state_nxt = (timestep == 4'(NUM_TIMESTEPS)) ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_packet = out_pkt;
    assign done       = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            started   <= 1'b0;
            timestep  <= '0;
            err       <= 1'b0;
            spe_done  <= '0;
            bcast_idx <= '0;
            resp_pe   <= '0;
            resp_pot  <= '0;
            for (int unsigned i = 0; i < MAX_SPE; i++) begin
                ptr[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (accept && drop) begin
                err <= 1'b1;
            end
            if (rd_acc) begin
                resp_pe  <= pe;
                resp_pot <= rdata[SUM_WIDTH:1];
            end
            if (wr_acc) begin
                ptr[pe] <= ptr_last ? '0 : ptr[pe] + 1'b1;
            end
            if (ts_close) begin
                spe_done <= '0;
                timestep <= ts_inc;
            end else begin
                spe_done <= done_set;
            end
            if (state == ST_TS_BCAST && out_ready) begin
                bcast_idx <= bcast_last ? '0 : bcast_idx + 1'b1;
            end
        end
    end

`ifdef OMEM_SPIKE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count      <= '0;
            last_spike_count <= '0;
        end else if (ts_close) begin
            last_spike_count <= spike_count + 9'(in_pkt.data[0]);
            spike_count      <= '0;
        end else if (wr_acc && in_pkt.data[0]) begin
            spike_count <= spike_count + 9'd1;
        end
    end
`endif

    omem_array #(
        .DEPTH (DEPTH),
        .WIDTH (SUM_WIDTH + 1),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (waddr),
        .wdata (in_pkt.data[SUM_WIDTH:0]),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule
